// File: rtl/blowfish_cipher_core.sv
// Iterative Blowfish core: one Feistel round per cycle, P/S tables loaded through a cfg write port.
// One block in flight; result held in DONE until out_ready.
module blowfish_cipher_core #(
  parameter int ROUNDS  = 16,
  parameter int P_DEPTH = ROUNDS + 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic        in_decrypt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  input  logic        cfg_we,
  input  logic [10:0] cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic        cfg_err,
  output logic        busy
);

  localparam int PW = $clog2(P_DEPTH);
  localparam int CW = $clog2(ROUNDS + 1);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  state_t          state_q, state_d;
  logic [31:0]     xl_q, xl_d, xr_q, xr_d;
  logic [CW-1:0]   rnd_q, rnd_d;
  logic            dec_q, dec_d;
  logic [63:0]     out_q, out_d;
  logic            err_q;
  logic            rdy_en_q;

  // Tables are deliberately outside the reset domain so keys survive a reset.
  logic [31:0] p_mem  [P_DEPTH];
  logic [31:0] s1_mem [256];
  logic [31:0] s2_mem [256];
  logic [31:0] s3_mem [256];
  logic [31:0] s4_mem [256];

  logic p_hit, s_hit, wr_ok;
  assign p_hit = (cfg_addr < 11'(P_DEPTH));
  assign s_hit = cfg_addr[10];
  assign wr_ok = cfg_we && (p_hit || s_hit) && (state_q == IDLE);

  always_ff @(posedge clock) begin
    if (wr_ok) begin
      if (s_hit) begin
        case (cfg_addr[9:8])
          2'd0:    s1_mem[cfg_addr[7:0]] <= cfg_wdata;
          2'd1:    s2_mem[cfg_addr[7:0]] <= cfg_wdata;
          2'd2:    s3_mem[cfg_addr[7:0]] <= cfg_wdata;
          default: s4_mem[cfg_addr[7:0]] <= cfg_wdata;
        endcase
      end else begin
        p_mem[cfg_addr[PW-1:0]] <= cfg_wdata;
      end
    end
  end

  logic [PW-1:0] pk_idx;
  logic [31:0]   xl_x, fx, fin_l, fin_r;

  assign pk_idx = dec_q ? (PW'(ROUNDS + 1) - PW'(rnd_q)) : PW'(rnd_q);
  assign xl_x   = xl_q ^ p_mem[pk_idx];
  assign fx     = ((s1_mem[xl_x[31:24]] + s2_mem[xl_x[23:16]]) ^ s3_mem[xl_x[15:8]])
                  + s4_mem[xl_x[7:0]];
  // FINAL first undoes the last swap, then applies the two whitening keys.
  assign fin_r  = xl_q ^ (dec_q ? p_mem[PW'(1)] : p_mem[PW'(ROUNDS)]);
  assign fin_l  = xr_q ^ (dec_q ? p_mem[PW'(0)] : p_mem[PW'(ROUNDS + 1)]);

  always_comb begin
    state_d = state_q;
    xl_d    = xl_q;
    xr_d    = xr_q;
    rnd_d   = rnd_q;
    dec_d   = dec_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          xl_d    = in_data[63:32];
          xr_d    = in_data[31:0];
          dec_d   = in_decrypt;
          rnd_d   = '0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        xl_d  = xr_q ^ fx;
        xr_d  = xl_x;
        rnd_d = rnd_q + CW'(1);
        if (rnd_q == CW'(ROUNDS - 1)) state_d = FINAL;
      end
      FINAL: begin
        out_d   = {fin_l, fin_r};
        state_d = DONE;
      end
      default: begin
        if (out_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      xl_q     <= '0;
      xr_q     <= '0;
      rnd_q    <= '0;
      dec_q    <= 1'b0;
      out_q    <= '0;
      err_q    <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      xl_q     <= xl_d;
      xr_q     <= xr_d;
      rnd_q    <= rnd_d;
      dec_q    <= dec_d;
      out_q    <= out_d;
      err_q    <= cfg_we && (p_hit || s_hit) && (state_q != IDLE);
      rdy_en_q <= 1'b1;
    end
  end

  // in_ready stays low through reset and rises on the first clock after release.
  assign in_ready  = (state_q == IDLE) && rdy_en_q;
  assign out_valid = (state_q == DONE);
  assign out_data  = out_q;
  assign cfg_err   = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_blowfish_cipher_core.sv
// Directed bench for blowfish_cipher_core: a 16-round and a 4-round instance with hand-computed vectors.
module tb_blowfish_cipher_core;

  logic        clock;
  logic        rst_n;
  logic        in_valid16, in_valid4;
  logic        in_ready16, in_ready4;
  logic [63:0] in_data;
  logic        in_decrypt;
  logic        out_valid16, out_valid4;
  logic        out_ready;
  logic [63:0] out_data16, out_data4;
  logic        cfg_we16, cfg_we4;
  logic [10:0] cfg_addr;
  logic [31:0] cfg_wdata;
  logic        cfg_err16, cfg_err4;
  logic        busy16, busy4;

  int n_cmp = 0;
  int n_err = 0;

  blowfish_cipher_core #(.ROUNDS(16)) u_dut16 (
    .clock(clock), .reset_n(rst_n),
    .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data), .in_decrypt(in_decrypt),
    .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16),
    .cfg_we(cfg_we16), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_err(cfg_err16), .busy(busy16)
  );

  blowfish_cipher_core #(.ROUNDS(4)) u_dut4 (
    .clock(clock), .reset_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data), .in_decrypt(in_decrypt),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .cfg_we(cfg_we4), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_err(cfg_err4), .busy(busy4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] msk, input logic [10:0] a, input logic [31:0] d);
    @(negedge clock);
    cfg_addr  = a;
    cfg_wdata = d;
    cfg_we16  = msk[0];
    cfg_we4   = msk[1];
    @(negedge clock);
    cfg_we16  = 1'b0;
    cfg_we4   = 1'b0;
  endtask

  // Returns just after the accept edge; scrambles the inputs so only latched values matter.
  task automatic start_block(input bit sel, input logic [63:0] d, input bit dec);
    @(negedge clock);
    in_data    = d;
    in_decrypt = dec;
    if (sel) in_valid4 = 1'b1;
    else     in_valid16 = 1'b1;
    @(posedge clock);
    #1;
    in_valid16 = 1'b0;
    in_valid4  = 1'b0;
    in_decrypt = ~dec;
    in_data    = '1;
  endtask

  task automatic wait_done(input bit sel, output int lat);
    lat = 0;
    do begin
      @(posedge clock);
      #1;
      lat++;
    end while (!(sel ? out_valid4 : out_valid16) && lat < 60);
  endtask

  task automatic run_block(input string tag, input bit sel, input logic [63:0] d, input bit dec,
                           input logic [63:0] exp, input int exp_lat);
    int lat;
    start_block(sel, d, dec);
    wait_done(sel, lat);
    check_eq($sformatf("%s_data", tag), sel ? out_data4 : out_data16, exp);
    check_eq($sformatf("%s_lat", tag), 64'(lat), 64'(exp_lat));
    @(posedge clock);
    #1;
  endtask

  initial begin
    int lat;
    int stray;
    rst_n      = 1'b0;
    in_valid16 = 1'b0;
    in_valid4  = 1'b0;
    in_data    = '0;
    in_decrypt = 1'b0;
    out_ready  = 1'b1;
    cfg_we16   = 1'b0;
    cfg_we4    = 1'b0;
    cfg_addr   = '0;
    cfg_wdata  = '0;

    #12;
    check_eq("rst_busy",      64'(busy16),      64'd0);
    check_eq("rst_out_valid", 64'(out_valid16), 64'd0);
    check_eq("rst_out_data",  out_data16,       64'd0);
    check_eq("rst_cfg_err",   64'(cfg_err16),   64'd0);
    check_eq("rst_in_ready",  64'(in_ready16),  64'd0);
    @(negedge clock);
    rst_n = 1'b1;
    #1;
    check_eq("rel_in_ready_pre", 64'(in_ready16), 64'd0);
    @(posedge clock);
    #1;
    check_eq("rel_in_ready_post", 64'(in_ready16), 64'd1);

    for (int i = 0; i < 18; i++) cfg_write(2'b01, 11'(i), 32'd0);
    for (int i = 0; i < 6; i++)  cfg_write(2'b10, 11'(i), 32'd0);
    for (int i = 11'h400; i < 11'h800; i++) cfg_write(2'b11, 11'(i), 32'd0);

    run_block("zero16", 1'b0, 64'h0123456789ABCDEF, 1'b0, 64'h89ABCDEF01234567, 17);
    run_block("zero4",  1'b1, 64'h0123456789ABCDEF, 1'b0, 64'h89ABCDEF01234567, 5);

    cfg_write(2'b01, 11'h000, 32'h00000001);
    run_block("p0_enc", 1'b0, 64'h0123456789ABCDEF, 1'b0, 64'h89ABCDEF01234566, 17);
    run_block("p0_dec", 1'b0, 64'h89ABCDEF01234566, 1'b1, 64'h0123456789ABCDEF, 17);

    // Stall in DONE with the consumer holding off.
    out_ready = 1'b0;
    start_block(1'b0, 64'h0123456789ABCDEF, 1'b0);
    wait_done(1'b0, lat);
    check_eq("stall_lat", 64'(lat), 64'd17);
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      check_eq($sformatf("stall_valid_%0d", i), 64'(out_valid16), 64'd1);
      check_eq($sformatf("stall_data_%0d", i),  out_data16, 64'h89ABCDEF01234566);
      check_eq($sformatf("stall_ready_%0d", i), 64'(in_ready16), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    check_eq("stall_release_valid", 64'(out_valid16), 64'd0);
    check_eq("stall_release_ready", 64'(in_ready16),  64'd1);

    // Reset in round 5 aborts the block; tables must survive.
    start_block(1'b0, 64'h0123456789ABCDEF, 1'b0);
    repeat (5) @(posedge clock);
    #1;
    check_eq("mid_busy_before", 64'(busy16), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy",      64'(busy16),      64'd0);
    check_eq("mid_rst_out_valid", 64'(out_valid16), 64'd0);
    check_eq("mid_rst_out_data",  out_data16,       64'd0);
    @(negedge clock);
    @(negedge clock);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clock);
      #1;
      if (out_valid16) stray++;
    end
    check_eq("mid_no_out_valid", 64'(stray), 64'd0);
    check_eq("mid_in_ready", 64'(in_ready16), 64'd1);
    run_block("mid_after", 1'b0, 64'h0123456789ABCDEF, 1'b0, 64'h89ABCDEF01234566, 17);

    // A mapped write while busy is dropped and flagged; an unmapped one is silent.
    cfg_write(2'b01, 11'h000, 32'h00000000);
    start_block(1'b0, 64'h0, 1'b0);
    @(negedge clock);
    cfg_addr  = 11'h400;
    cfg_wdata = 32'hDEADBEEF;
    cfg_we16  = 1'b1;
    @(posedge clock);
    #1;
    cfg_we16 = 1'b0;
    check_eq("busy_err_pulse", 64'(cfg_err16), 64'd1);
    @(posedge clock);
    #1;
    check_eq("busy_err_clear", 64'(cfg_err16), 64'd0);
    @(negedge clock);
    cfg_addr = 11'h012;
    cfg_we16 = 1'b1;
    @(posedge clock);
    #1;
    cfg_we16 = 1'b0;
    @(posedge clock);
    #1;
    check_eq("unmapped_busy", 64'(busy16), 64'd1);
    check_eq("unmapped_err",  64'(cfg_err16), 64'd0);
    wait_done(1'b0, lat);
    check_eq("busy_wr_block", out_data16, 64'd0);
    @(posedge clock);
    #1;
    run_block("s1_unchanged", 1'b0, 64'h0, 1'b0, 64'h0, 17);
    cfg_write(2'b01, 11'h400, 32'hDEADBEEF);
    check_eq("idle_wr_err", 64'(cfg_err16), 64'd0);
    run_block("s1_updated", 1'b0, 64'h0, 1'b0, 64'h00000000DEADBEEF, 17);
    cfg_write(2'b01, 11'h400, 32'h00000000);

    // Exercise every S-box and the modular add on the 4-round build.
    cfg_write(2'b10, 11'h401, 32'hFFFFFFF0);
    cfg_write(2'b10, 11'h500, 32'h00000020);
    cfg_write(2'b10, 11'h600, 32'h00000003);
    cfg_write(2'b10, 11'h700, 32'h00000400);
    cfg_write(2'b10, 11'h000, 32'h01000000);
    run_block("f4_enc", 1'b1, 64'h0, 1'b0, 64'h0000040001000400, 5);
    run_block("f4_dec", 1'b1, 64'h0000040001000400, 1'b1, 64'h0, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
